// File: rtl/mem_axi_bridge.sv
// Bridges the MEM stage's single-outstanding load/store request onto the simplified AXI4 RAM port.
// Define MEM_BRIDGE_MISALIGN_CHECK_EN to reject misaligned accesses with resp_err instead of aligning them.
module mem_axi_bridge #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(32'h8000_0000)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [63:0]       req_wdata,
   output logic              resp_valid,
   output logic [63:0]       resp_rdata,
   output logic              resp_err,
   output logic [31:0]       io_awaddr,
   output logic              io_awvalid,
   input  logic              io_awready,
   output logic [31:0]       io_araddr,
   output logic              io_arvalid,
   input  logic              io_arready,
   input  logic [63:0]       io_rdata,
   output logic [63:0]       io_wdata,
   output logic [7:0]        io_wstrb,
   output logic              io_wvalid,
   input  logic              io_wready,
   input  logic              io_bvalid
);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [63:0] resp_rdata_q, resp_rdata_d;
   logic        arvalid_q, arvalid_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic [31:0] araddr_q, araddr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wstrb_q, wstrb_d;
   logic [2:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;

   logic [ADDR_W-1:0] rel_addr, word_addr;
   logic [2:0]        raw_off, off_mask, eff_off;
   logic [7:0]        strb_base;
   logic              reject;
   logic [63:0]       rd_shift, rd_ext;
   logic              aw_hs, w_hs;

   // Request-side address/lane decode, evaluated on the accept cycle.
   always_comb begin
      rel_addr  = req_addr - RAM_BASE;
      word_addr = rel_addr & ~ADDR_W'(7);
      raw_off   = req_addr[2:0];
      case (req_size)
         2'd0:    begin off_mask = 3'b000; strb_base = 8'h01; end
         2'd1:    begin off_mask = 3'b001; strb_base = 8'h03; end
         2'd2:    begin off_mask = 3'b011; strb_base = 8'h0F; end
         default: begin off_mask = 3'b111; strb_base = 8'hFF; end
      endcase
      eff_off = raw_off & ~off_mask;
`ifdef MEM_BRIDGE_MISALIGN_CHECK_EN
      reject = |(raw_off & off_mask);
`else
      reject = 1'b0;
`endif
   end

   always_comb begin
      rd_shift = io_rdata >> {off_q, 3'b000};
      case (size_q)
         2'd0:    rd_ext = uns_q ? {56'd0, rd_shift[7:0]}  : {{56{rd_shift[7]}},  rd_shift[7:0]};
         2'd1:    rd_ext = uns_q ? {48'd0, rd_shift[15:0]} : {{48{rd_shift[15]}}, rd_shift[15:0]};
         2'd2:    rd_ext = uns_q ? {32'd0, rd_shift[31:0]} : {{32{rd_shift[31]}}, rd_shift[31:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   assign aw_hs = awvalid_q & io_awready;
   assign w_hs  = wvalid_q & io_wready;

   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      arvalid_d    = arvalid_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      awaddr_d     = awaddr_q;
      araddr_d     = araddr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      off_d        = off_q;
      size_d       = size_q;
      uns_d        = uns_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               off_d  = eff_off;
               size_d = req_size;
               uns_d  = req_unsigned;
               if (reject) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else if (req_wen) begin
                  state_d   = S_W;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = 32'(word_addr);
                  wdata_d   = req_wdata << {eff_off, 3'b000};
                  wstrb_d   = strb_base << eff_off;
               end else begin
                  state_d   = S_AR;
                  arvalid_d = 1'b1;
                  araddr_d  = 32'(word_addr);
               end
            end
         end
         S_AR: begin
            if (io_arready) begin
               arvalid_d = 1'b0;
               state_d   = S_R;
            end
         end
         S_R: begin
            resp_rdata_d = rd_ext;
            resp_err_d   = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
         end
         S_W: begin
            // Address and data channels retire independently; leave once both have.
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_B;
            end
         end
         S_B: begin
            if (io_bvalid) begin
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         arvalid_q    <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         awaddr_q     <= '0;
         araddr_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         off_q        <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         arvalid_q    <= arvalid_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         awaddr_q     <= awaddr_d;
         araddr_q     <= araddr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         off_q        <= off_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign io_arvalid = arvalid_q;
   assign io_awvalid = awvalid_q;
   assign io_wvalid  = wvalid_q;
   assign io_awaddr  = awaddr_q;
   assign io_araddr  = araddr_q;
   assign io_wdata   = wdata_q;
   assign io_wstrb   = wstrb_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Self-checking bench for mem_axi_bridge: behavioural AXI RAM with programmable stalls,
// byte-level reference memory, directed vector table, hand sequences and random traffic.
module tb_mem_axi_bridge;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic [63:0] req_wdata = '0;
   logic        req_ready, resp_valid, resp_err;
   logic [63:0] resp_rdata;
   logic [31:0] io_awaddr, io_araddr;
   logic        io_awvalid, io_arvalid, io_wvalid;
   logic [63:0] io_wdata;
   logic [7:0]  io_wstrb;
   logic        io_awready = 1'b0, io_arready = 1'b0, io_wready = 1'b0, io_bvalid = 1'b0;
   logic [63:0] io_rdata = '0;

   int tests = 0;
   int fails = 0;

   mem_axi_bridge #(.ADDR_W(32), .RAM_BASE(BASE)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .io_awaddr(io_awaddr), .io_awvalid(io_awvalid), .io_awready(io_awready),
      .io_araddr(io_araddr), .io_arvalid(io_arvalid), .io_arready(io_arready),
      .io_rdata(io_rdata), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
      .io_wvalid(io_wvalid), .io_wready(io_wready), .io_bvalid(io_bvalid)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   // RAM side: 2 KiB of 64-bit words, ready held low for a programmable number of valid cycles
   logic [63:0] ram [0:255];
   logic [7:0]  ref_mem [0:2047];
   int ar_stall = 0, aw_stall = 0, w_stall = 0, b_delay = 0;
   int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   bit rd_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
   logic [31:0] rd_addr = '0, wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic [7:0]  wr_strb = '0;

   initial begin
      forever begin
         @(negedge clock);
         io_bvalid = 1'b0;
         if (!reset) begin
            rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         end else begin
            if (rd_pend) begin
               io_rdata = ram[rd_addr[10:3]];
               rd_pend  = 0;
            end
            if (b_pend) begin
               if (b_cnt == 0) begin io_bvalid = 1'b1; b_pend = 0; end
               else b_cnt--;
            end
            if (io_arvalid) begin
               io_arready = (ar_cnt >= ar_stall);
               ar_cnt++;
               if (io_arready) begin rd_pend = 1; rd_addr = io_araddr; ar_cnt = 0; end
            end else begin
               ar_cnt = 0; io_arready = (ar_stall == 0);
            end
            if (io_awvalid) begin
               io_awready = (aw_cnt >= aw_stall);
               aw_cnt++;
               if (io_awready) begin aw_got = 1; wr_addr = io_awaddr; end
            end else begin
               aw_cnt = 0; io_awready = (aw_stall == 0);
            end
            if (io_wvalid) begin
               io_wready = (w_cnt >= w_stall);
               w_cnt++;
               if (io_wready) begin w_got = 1; wr_data = io_wdata; wr_strb = io_wstrb; end
            end else begin
               w_cnt = 0; io_wready = (w_stall == 0);
            end
            if (aw_got && w_got) begin
               for (int j = 0; j < 8; j++)
                  if (wr_strb[j]) ram[wr_addr[10:3]][8*j +: 8] = wr_data[8*j +: 8];
               aw_got = 0; w_got = 0; b_pend = 1; b_cnt = b_delay;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_word(input int idx, input logic [63:0] w);
      ram[idx] = w;
      for (int j = 0; j < 8; j++) ref_mem[8*idx + j] = w[8*j +: 8];
   endtask

   // Reference model: byte-addressed memory, accesses aligned down to their natural size
   function automatic logic [31:0] eff_addr(input logic [31:0] addr, input logic [1:0] size);
      int unsigned nb = 1 << size;
      return (addr - BASE) & ~(nb - 1);
   endfunction

   function automatic logic [63:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
      int unsigned nb = 1 << size;
      logic [31:0] a = eff_addr(addr, size);
      logic [63:0] v = '0;
      for (int unsigned i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a + i];
      if (!uns && nb < 8 && v[8*nb-1])
         for (int unsigned i = 8*nb; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [63:0] wdata);
      int unsigned nb = 1 << size;
      logic [31:0] a = eff_addr(addr, size);
      for (int unsigned i = 0; i < nb; i++) ref_mem[a + i] = wdata[8*i +: 8];
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"},  64'(req_ready),  64'd1);
      chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      chk({tag, "_resp_err"},   64'(resp_err),   64'd0);
      chk({tag, "_resp_rdata"}, resp_rdata,      64'd0);
      chk({tag, "_valids"},     64'({io_arvalid, io_awvalid, io_wvalid}), 64'd0);
      chk({tag, "_awaddr"},     64'(io_awaddr),  64'd0);
      chk({tag, "_araddr"},     64'(io_araddr),  64'd0);
      chk({tag, "_wdata"},      io_wdata,        64'd0);
      chk({tag, "_wstrb"},      64'(io_wstrb),   64'd0);
   endtask

   // Issues one request; latency counts cycles from the accept cycle to the resp_valid cycle.
   task automatic do_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata,
                         input int ars, input int aws, input int ws, input int bd,
                         output int lat, output logic [63:0] rdata, output logic err,
                         output logic [31:0] c_addr, output logic [7:0] c_strb,
                         output logic [63:0] c_wdata, output int n_ar, output int n_aw, output int n_w);
      ar_stall = ars; aw_stall = aws; w_stall = ws; b_delay = bd;
      lat = -1; rdata = '0; err = 1'b0; c_addr = '0; c_strb = '0; c_wdata = '0;
      n_ar = 0; n_aw = 0; n_w = 0;
      @(negedge clock);
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (k == 1) req_valid = 1'b0;
         if (io_arvalid) begin n_ar++; c_addr = io_araddr; end
         if (io_awvalid) begin n_aw++; c_addr = io_awaddr; end
         if (io_wvalid)  begin n_w++;  c_strb = io_wstrb; c_wdata = io_wdata; end
         if (resp_valid) begin lat = k; rdata = resp_rdata; err = resp_err; break; end
      end
   endtask

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [63:0] wdata;
      logic        pre_en;
      logic [63:0] pre_word;
      logic [31:0] exp_addr;
      logic [7:0]  exp_strb;
      logic [63:0] exp_wdata;
      logic [63:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int lat, n_ar, n_aw, n_w;
      logic [63:0] rdata, c_wdata;
      logic err;
      logic [31:0] c_addr;
      logic [7:0] c_strb;

      for (int i = 0; i < 256; i++) set_word(i, {$urandom, $urandom});

      vecs.push_back('{1'b1, 32'h8000_0104, 2'd2, 1'b0, 64'hDEADBEEF, 1'b0, 64'd0,
                       32'h100, 8'hF0, 64'hDEADBEEF_0000_0000, 64'd0});
      vecs.push_back('{1'b0, 32'h8000_0001, 2'd0, 1'b0, 64'd0, 1'b1, 64'h8000,
                       32'h000, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF80});
      vecs.push_back('{1'b0, 32'h8000_0001, 2'd0, 1'b1, 64'd0, 1'b0, 64'd0,
                       32'h000, 8'h00, 64'd0, 64'h80});
      vecs.push_back('{1'b1, 32'h8000_0208, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0,
                       32'h208, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0});
      vecs.push_back('{1'b0, 32'h8000_0208, 2'd3, 1'b1, 64'd0, 1'b0, 64'd0,
                       32'h208, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF});
      vecs.push_back('{1'b0, 32'h8000_0202, 2'd1, 1'b0, 64'd0, 1'b1, 64'hF122_3344_8566_7788,
                       32'h200, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_8566});
      vecs.push_back('{1'b0, 32'h8000_0204, 2'd2, 1'b1, 64'd0, 1'b0, 64'd0,
                       32'h200, 8'h00, 64'd0, 64'h0000_0000_F122_3344});
      vecs.push_back('{1'b0, 32'h8000_0204, 2'd2, 1'b0, 64'd0, 1'b0, 64'd0,
                       32'h200, 8'h00, 64'd0, 64'hFFFF_FFFF_F122_3344});
      vecs.push_back('{1'b1, 32'h8000_0107, 2'd0, 1'b0, 64'hAB, 1'b0, 64'd0,
                       32'h100, 8'h80, 64'hAB00_0000_0000_0000, 64'd0});
      vecs.push_back('{1'b0, 32'h8000_0100, 2'd3, 1'b1, 64'd0, 1'b0, 64'd0,
                       32'h100, 8'h00, 64'd0, 64'd0});
`ifndef MEM_BRIDGE_MISALIGN_CHECK_EN
      vecs.push_back('{1'b1, 32'h8000_0003, 2'd1, 1'b0, 64'hABCD, 1'b0, 64'd0,
                       32'h000, 8'h0C, 64'h0000_0000_ABCD_0000, 64'd0});
      vecs.push_back('{1'b0, 32'h8000_0207, 2'd2, 1'b1, 64'd0, 1'b0, 64'd0,
                       32'h200, 8'h00, 64'd0, 64'h0000_0000_F122_3344});
`endif

      repeat (3) @(negedge clock);
      chk_reset_vals("por");
      reset = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].pre_en) set_word(int'((vecs[i].addr - BASE) >> 3), vecs[i].pre_word);
         // dword load at 0x100 mixes earlier word and byte stores; expectation comes from the model
         if (vecs[i].addr == 32'h8000_0100) vecs[i].exp_rdata = ref_load(vecs[i].addr, 2'd3, 1'b1);
         do_req(vecs[i].wen, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, 0, 0, 0, 0,
                lat, rdata, err, c_addr, c_strb, c_wdata, n_ar, n_aw, n_w);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
         chk($sformatf("vec%0d_addr", i), 64'(c_addr), 64'(vecs[i].exp_addr));
         chk($sformatf("vec%0d_err", i), 64'(err), 64'd0);
         if (vecs[i].wen) begin
            chk($sformatf("vec%0d_wstrb", i), 64'(c_strb), 64'(vecs[i].exp_strb));
            chk($sformatf("vec%0d_wdata", i), c_wdata, vecs[i].exp_wdata);
            ref_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
         end else begin
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         end
      end

`ifdef MEM_BRIDGE_MISALIGN_CHECK_EN
      do_req(1'b1, 32'h8000_0003, 2'd1, 1'b0, 64'hABCD, 0, 0, 0, 0,
             lat, rdata, err, c_addr, c_strb, c_wdata, n_ar, n_aw, n_w);
      chk("misal_st_latency", 64'(lat), 64'd1);
      chk("misal_st_err", 64'(err), 64'd1);
      chk("misal_st_ram_valids", 64'(n_ar + n_aw + n_w), 64'd0);
      do_req(1'b0, 32'h8000_0207, 2'd2, 1'b1, 64'd0, 0, 0, 0, 0,
             lat, rdata, err, c_addr, c_strb, c_wdata, n_ar, n_aw, n_w);
      chk("misal_ld_latency", 64'(lat), 64'd1);
      chk("misal_ld_err", 64'(err), 64'd1);
      chk("misal_ld_rdata", rdata, 64'd0);
      chk("misal_ld_ram_valids", 64'(n_ar + n_aw + n_w), 64'd0);
`endif

      // Backpressure corner cases
      do_req(1'b1, 32'h8000_0300, 2'd3, 1'b0, 64'h1111_2222_3333_4444, 0, 3, 0, 0,
             lat, rdata, err, c_addr, c_strb, c_wdata, n_ar, n_aw, n_w);
      ref_store(32'h8000_0300, 2'd3, 64'h1111_2222_3333_4444);
      chk("aw_stall3_latency", 64'(lat), 64'd6);
      chk("aw_stall3_awvalid_cycles", 64'(n_aw), 64'd4);
      chk("aw_stall3_wvalid_cycles", 64'(n_w), 64'd1);
      do_req(1'b0, 32'h8000_0300, 2'd3, 1'b0, 64'd0, 2, 0, 0, 0,
             lat, rdata, err, c_addr, c_strb, c_wdata, n_ar, n_aw, n_w);
      chk("ar_stall2_latency", 64'(lat), 64'd5);
      chk("ar_stall2_arvalid_cycles", 64'(n_ar), 64'd3);
      chk("ar_stall2_rdata", rdata, 64'h1111_2222_3333_4444);
      do_req(1'b1, 32'h8000_0310, 2'd2, 1'b0, 64'h5566_7788, 0, 0, 2, 1,
             lat, rdata, err, c_addr, c_strb, c_wdata, n_ar, n_aw, n_w);
      ref_store(32'h8000_0310, 2'd2, 64'h5566_7788);
      chk("w_stall2_b1_latency", 64'(lat), 64'd6);
      chk("w_stall2_awvalid_cycles", 64'(n_aw), 64'd1);
      chk("w_stall2_wvalid_cycles", 64'(n_w), 64'd3);

      // Reset while waiting in B: store is already accepted by the RAM but never answered
      ar_stall = 0; aw_stall = 0; w_stall = 0; b_delay = 4;
      @(negedge clock);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0400; req_size = 2'd3;
      req_unsigned = 1'b0; req_wdata = 64'hCAFE_F00D_1234_5678;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      chk("inB_valids_low", 64'({io_awvalid, io_wvalid, resp_valid, req_ready}), 64'd0);
      reset = 1'b0;
      #1;
      chk_reset_vals("midB");
      ref_store(32'h8000_0400, 2'd3, 64'hCAFE_F00D_1234_5678);
      for (int c = 0; c < 7; c++) begin
         @(negedge clock);
         if (c == 1) reset = 1'b1;
         chk($sformatf("post_reset_quiet%0d", c), 64'({resp_valid, req_ready}), 64'b01);
      end
      do_req(1'b0, 32'h8000_0400, 2'd3, 1'b1, 64'd0, 0, 0, 0, 0,
             lat, rdata, err, c_addr, c_strb, c_wdata, n_ar, n_aw, n_w);
      chk("after_reset_latency", 64'(lat), 64'd3);
      chk("after_reset_rdata", rdata, 64'hCAFE_F00D_1234_5678);

      // Random traffic against the byte-level reference memory
      for (int t = 0; t < 80; t++) begin
         logic        wen, uns, mis;
         logic [1:0]  sz;
         logic [31:0] a, ea;
         logic [63:0] wd;
         logic [7:0]  es;
         int          ars, aws, ws, bd, el;
         int unsigned nb;
         wen = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
         a   = BASE + $urandom_range(0, 2047);
         wd  = {$urandom, $urandom};
         ars = $urandom_range(0, 3); aws = $urandom_range(0, 3);
         ws  = $urandom_range(0, 3); bd = $urandom_range(0, 2);
         nb  = 1 << sz;
`ifdef MEM_BRIDGE_MISALIGN_CHECK_EN
         mis = ((a % nb) != 0);
`else
         mis = 1'b0;
`endif
         ea = eff_addr(a, sz);
         es = '0;
         for (int unsigned i = 0; i < nb; i++) es[(ea % 8) + i] = 1'b1;
         el = mis ? 1 : (wen ? 3 + ((aws > ws) ? aws : ws) + bd : 3 + ars);
         do_req(wen, a, sz, uns, wd, ars, aws, ws, bd,
                lat, rdata, err, c_addr, c_strb, c_wdata, n_ar, n_aw, n_w);
         chk($sformatf("rnd%0d_latency", t), 64'(lat), 64'(el));
         chk($sformatf("rnd%0d_err", t), 64'(err), 64'(mis));
         if (mis) begin
            chk($sformatf("rnd%0d_no_ram", t), 64'(n_ar + n_aw + n_w), 64'd0);
            if (!wen) chk($sformatf("rnd%0d_err_rdata", t), rdata, 64'd0);
         end else begin
            chk($sformatf("rnd%0d_addr", t), 64'(c_addr), 64'(ea & ~32'd7));
            if (wen) begin
               chk($sformatf("rnd%0d_wstrb", t), 64'(c_strb), 64'(es));
               ref_store(a, sz, wd);
            end else begin
               chk($sformatf("rnd%0d_rdata", t), rdata, ref_load(a, sz, uns));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
